// File: rtl/aes_uart_cmd_ctrl.sv
// aes_uart_cmd_ctrl: parses framed host commands (key load / encrypt) from the UART byte
//   stream, drives the AES key-load and encrypt handshakes and returns the result bytes.
// Latency: 16th frame byte to KDRDY_AES/EN_AES is 2 cycles with BUSY_AES low; DVLD_AES to first TX_VLD is 1 cycle.
// Backpressure: TX_VLD holds with TX_DATA stable until TX_RDY; RX bytes outside IDLE/RX_* are dropped.
// Ports: RX_DATA/RX_VLD host bytes in; TX_DATA/TX_VLD/TX_RDY host bytes out;
//   KIN_AES/DIN_AES/KDRDY_AES/EN_AES to the core; BUSY_AES/KVLD_AES/DVLD_AES/DOUT_AES from the core;
//   CTRL_BSY high whenever the controller is not idle.
module aes_uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT  = 1_000_000,
  parameter logic [7:0]  CMD_KEY  = 8'h4B,
  parameter logic [7:0]  CMD_ENC  = 8'h50,
  parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [7:0]   RX_DATA,
  input  logic         RX_VLD,
  output logic [7:0]   TX_DATA,
  output logic         TX_VLD,
  input  logic         TX_RDY,
  output logic [127:0] KIN_AES,
  output logic [127:0] DIN_AES,
  output logic         KDRDY_AES,
  output logic         EN_AES,
  input  logic         BUSY_AES,
  input  logic         KVLD_AES,
  input  logic         DVLD_AES,
  input  logic [127:0] DOUT_AES,
  output logic         CTRL_BSY
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RX_KEY, RX_PT, KEY_LOAD, KEY_WAIT, ENC_START, ENC_WAIT, TX
  } state_t;

  state_t         state;
  logic [3:0]     rx_cnt;
  logic [119:0]   rx_sr;     // only the 15 bytes already received need storing
  logic [119:0]   tx_sr;     // bytes still to be presented after the one on TX_DATA
  logic [4:0]     tx_left;   // bytes remaining including the one on TX_DATA
  logic [TW-1:0]  tmo_cnt;
  logic           key_vld;

  // Full 128-bit word as it would stand after accepting the current byte.
  logic [127:0]   rx_word;
  assign rx_word  = {rx_sr, RX_DATA};
  assign CTRL_BSY = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rx_cnt    <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      tx_left   <= '0;
      tmo_cnt   <= '0;
      key_vld   <= 1'b0;
      TX_DATA   <= '0;
      TX_VLD    <= 1'b0;
      KIN_AES   <= '0;
      DIN_AES   <= '0;
      KDRDY_AES <= 1'b0;
      EN_AES    <= 1'b0;
    end else begin
      // Handshake strobes are single-cycle by construction.
      KDRDY_AES <= 1'b0;
      EN_AES    <= 1'b0;
      if (KVLD_AES) key_vld <= 1'b1;

      case (state)
        IDLE: begin
          if (RX_VLD) begin
            rx_cnt <= '0;
            if (RX_DATA == CMD_KEY)      state <= RX_KEY;
            else if (RX_DATA == CMD_ENC) state <= RX_PT;
          end
        end

        RX_KEY, RX_PT: begin
          if (RX_VLD) begin
            rx_sr  <= rx_word[119:0];
            rx_cnt <= rx_cnt + 4'd1;
            if (rx_cnt == 4'd15) begin
              if (state == RX_KEY) begin
                KIN_AES <= rx_word;
                state   <= KEY_LOAD;
              end else begin
                DIN_AES <= rx_word;
                if (key_vld) begin
                  state <= ENC_START;
                end else begin
                  // No key loaded: answer with the error byte instead of encrypting.
                  TX_DATA <= ERR_BYTE;
                  TX_VLD  <= 1'b1;
                  tx_left <= 5'd1;
                  state   <= TX;
                end
              end
            end
          end
        end

        KEY_LOAD: begin
          if (!BUSY_AES) begin
            KDRDY_AES <= 1'b1;
            tmo_cnt   <= '0;
            state     <= KEY_WAIT;
          end
        end

        KEY_WAIT: begin
          if (KVLD_AES) begin
            TX_DATA <= CMD_KEY;
            TX_VLD  <= 1'b1;
            tx_left <= 5'd1;
            state   <= TX;
          end else if (tmo_cnt == TMO_LAST) begin
            // A key that never finished expanding cannot be trusted.
            key_vld <= 1'b0;
            TX_DATA <= ERR_BYTE;
            TX_VLD  <= 1'b1;
            tx_left <= 5'd1;
            state   <= TX;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        ENC_START: begin
          if (!BUSY_AES) begin
            EN_AES  <= 1'b1;
            tmo_cnt <= '0;
            state   <= ENC_WAIT;
          end
        end

        ENC_WAIT: begin
          // Result arriving on the timeout cycle still counts as success.
          if (DVLD_AES) begin
            TX_DATA <= DOUT_AES[127:120];
            tx_sr   <= DOUT_AES[119:0];
            TX_VLD  <= 1'b1;
            tx_left <= 5'd16;
            state   <= TX;
          end else if (tmo_cnt == TMO_LAST) begin
            TX_DATA <= ERR_BYTE;
            TX_VLD  <= 1'b1;
            tx_left <= 5'd1;
            state   <= TX;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        TX: begin
          if (TX_VLD && TX_RDY) begin
            if (tx_left == 5'd1) begin
              TX_VLD <= 1'b0;
              state  <= IDLE;
            end else begin
              TX_DATA <= tx_sr[119:112];
              tx_sr   <= {tx_sr[111:0], 8'h00};
              tx_left <= tx_left - 5'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_uart_cmd_ctrl.sv
// tb_aes_uart_cmd_ctrl: directed bench for aes_uart_cmd_ctrl acting as host UART and AES core.
// Latency: checks the 2-cycle frame-to-strobe and 1-cycle DVLD-to-TX_VLD timing explicitly.
// Backpressure: TX_RDY is driven 1-in-3 during one ciphertext return; hold stability is monitored.
module tb_aes_uart_cmd_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_vld;
  logic [7:0]   tx_data;
  logic         tx_vld;
  logic         tx_rdy = 1'b1;
  logic [127:0] kin;
  logic [127:0] din;
  logic         kdrdy;
  logic         en;
  logic         busy;
  logic         kvld;
  logic         dvld;
  logic [127:0] dout;
  logic         bsy;

  int n_tests = 0;
  int n_fail  = 0;

  aes_uart_cmd_ctrl #(.TIMEOUT(100)) dut (
    .CLK(clk), .RST(rst),
    .RX_DATA(rx_data), .RX_VLD(rx_vld),
    .TX_DATA(tx_data), .TX_VLD(tx_vld), .TX_RDY(tx_rdy),
    .KIN_AES(kin), .DIN_AES(din), .KDRDY_AES(kdrdy), .EN_AES(en),
    .BUSY_AES(busy), .KVLD_AES(kvld), .DVLD_AES(dvld), .DOUT_AES(dout),
    .CTRL_BSY(bsy)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  // ---------------- monitors (sample on falling edge) ----------------
  logic [7:0] txq[$];
  int   kd_cnt = 0, en_cnt = 0, both_cnt = 0, long_cnt = 0, hold_err = 0;
  logic prev_hold = 1'b0, kd_prev = 1'b0, en_prev = 1'b0;
  logic [7:0] prev_dat = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      kd_prev   = 1'b0;
      en_prev   = 1'b0;
    end else begin
      if (tx_vld && tx_rdy) txq.push_back(tx_data);
      if (prev_hold && (!tx_vld || tx_data != prev_dat)) hold_err++;
      prev_hold = tx_vld && !tx_rdy;
      prev_dat  = tx_data;
      if (kdrdy) kd_cnt++;
      if (en) en_cnt++;
      if (kdrdy && en) both_cnt++;
      if ((kdrdy && kd_prev) || (en && en_prev)) long_cnt++;
      kd_prev = kdrdy;
      en_prev = en;
    end
  end

  // Transmitter ready: always ready, or 1-in-3 when backpressure is enabled.
  logic bp_mode = 1'b0;
  int   bp_ph   = 0;
  always @(posedge clk) begin
    #1;
    tx_rdy = bp_mode ? (bp_ph == 2) : 1'b1;
    bp_ph  = (bp_ph == 2) ? 0 : bp_ph + 1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // All drivers run at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge clk); #1;
    rx_vld  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input int base, input int step);
    send_byte(op);
    for (int i = 0; i < 16; i++) send_byte(8'(base + i * step));
  endtask

  task automatic pulse_kvld();
    kvld = 1'b1;
    @(posedge clk); #1;
    kvld = 1'b0;
  endtask

  task automatic reply(input logic [127:0] ct);
    repeat (4) @(posedge clk);
    #1;
    dout = ct;
    dvld = 1'b1;
    @(posedge clk); #1;
    dvld = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    for (int c = 0; c < budget && txq.size() < n; c++) @(posedge clk);
    #1;
    chk(tag, 128'(txq.size()), 128'(n));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int c = 0; c < budget && bsy; c++) @(posedge clk);
    #1;
    chk(tag, bsy, 1'b0);
  endtask

  function automatic logic [127:0] q_word();
    logic [127:0] w = '0;
    for (int i = 0; i < 16; i++) w = {w[119:0], (i < txq.size()) ? txq[i] : 8'h00};
    return w;
  endfunction

  function automatic logic [7:0] q_at(input int i);
    return (i < txq.size()) ? txq[i] : 8'hxx;
  endfunction

  // ---------------- stimulus ----------------
  int e0;

  initial begin
    rst = 1'b1; rx_data = '0; rx_vld = 1'b0; busy = 1'b0;
    kvld = 1'b0; dvld = 1'b0; dout = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_vld", tx_vld, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_kdrdy", kdrdy, 1'b0);
    chk("rst_en", en, 1'b0);
    chk("rst_kin", kin, '0);
    chk("rst_din", din, '0);
    chk("rst_bsy", bsy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Key load: 00..0F, KVLD 20 cycles after KDRDY.
    send_frame(8'h4B, 0, 1);
    chk("kd_early", kdrdy, 1'b0);
    @(posedge clk); #1;
    chk("kd_latency", kdrdy, 1'b1);
    chk("kin_value", kin, 128'h000102030405060708090a0b0c0d0e0f);
    @(posedge clk); #1;
    chk("kd_width", kdrdy, 1'b0);
    repeat (18) @(posedge clk);
    #1;
    pulse_kvld();
    wait_bytes("key_ack_cnt", 1, 50);
    chk("key_ack_byte", q_at(0), 8'h4B);
    wait_idle("key_idle", 50);
    chk("kd_pulses", kd_cnt, 1);

    // Encrypt: 00 11 .. FF, ciphertext returned by the core model.
    txq.delete();
    send_frame(8'h50, 0, 8'h11);
    @(posedge clk); #1;
    chk("en_latency", en, 1'b1);
    chk("din_value", din, 128'h00112233445566778899aabbccddeeff);
    repeat (3) @(posedge clk);
    #1;
    dout = CT1;
    dvld = 1'b1;
    chk("tx_vld_before", tx_vld, 1'b0);
    @(posedge clk); #1;
    dvld = 1'b0;
    chk("dvld_to_txvld", tx_vld, 1'b1);
    chk("first_ct_byte", tx_data, 8'h69);
    wait_bytes("ct1_cnt", 16, 100);
    chk("ct1_bytes", q_word(), CT1);
    wait_idle("ct1_idle", 20);

    // Backpressure on the ciphertext return.
    txq.delete();
    bp_mode = 1'b1;
    send_frame(8'h50, 8'h40, 3);
    reply(CT2);
    wait_bytes("ct2_cnt", 16, 200);
    repeat (10) @(posedge clk);
    #1;
    chk("ct2_no_dup", 128'(txq.size()), 128'd16);
    chk("ct2_bytes", q_word(), CT2);
    chk("tx_hold", hold_err, 0);
    bp_mode = 1'b0;
    chk("en_pulses", en_cnt, 2);
    chk("strobe_overlap", both_cnt, 0);
    chk("strobe_long", long_cnt, 0);

    // Encrypt without a key after reset, then a bad opcode.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    txq.delete();
    e0 = en_cnt;
    send_frame(8'h50, 0, 8'h11);
    wait_bytes("nokey_cnt", 1, 50);
    chk("nokey_err", q_at(0), 8'hEE);
    wait_idle("nokey_idle", 20);
    chk("nokey_no_en", en_cnt, e0);
    send_byte(8'h33);
    repeat (5) @(posedge clk);
    #1;
    chk("badop_idle", bsy, 1'b0);
    chk("badop_silent", 128'(txq.size()), 128'd1);

    // Busy hold then encrypt timeout.
    send_frame(8'h4B, 8'h10, 1);
    repeat (3) @(posedge clk);
    #1;
    pulse_kvld();
    wait_bytes("key2_ack_cnt", 2, 50);
    wait_idle("key2_idle", 20);
    txq.delete();
    busy = 1'b1;
    e0 = en_cnt;
    send_frame(8'h50, 0, 1);
    repeat (50) @(posedge clk);
    #1;
    chk("busy_no_en", en_cnt, e0);
    busy = 1'b0;
    @(posedge clk); #1;
    chk("en_after_busy", en, 1'b1);
    repeat (99) @(posedge clk);
    #1;
    chk("tmo_not_yet", tx_vld, 1'b0);
    @(posedge clk); #1;
    chk("tmo_vld", tx_vld, 1'b1);
    chk("tmo_byte", tx_data, 8'hEE);
    wait_idle("tmo_idle", 20);

    // Reset in the middle of a key frame.
    send_byte(8'h4B);
    for (int i = 0; i < 7; i++) send_byte(8'(8'h80 + i));
    #3;
    rst = 1'b1;
    #1;
    chk("arst_kin", kin, '0);
    chk("arst_bsy", bsy, 1'b0);
    chk("arst_tx_vld", tx_vld, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(8'h4B, 8'hA0, 1);
    @(posedge clk); #1;
    chk("rekey_kd", kdrdy, 1'b1);
    chk("rekey_kin", kin, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
